// File: rtl/uart_pkg.sv
// Shared constants and types for the UART echo path.
// FIFO sizing defaults, read FSM encoding, baud timing.
package uart_pkg;

  localparam int DEPTH_DEF    = 8;
  localparam int AW_DEF       = 3;

  localparam int CLK_HZ       = 100_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/uart_echo_fifo_if.sv
// Bundle between UART rx/tx side and the echo FIFO.
// master drives rx/tx status, slave is the echo block.
interface uart_echo_fifo_if
  import uart_pkg::*;
#(
  parameter int AW = AW_DEF
) ();

  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_busy;
  logic        tx_done;
  logic [7:0]  tx_din;
  logic        tx_start;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overflow;

  modport master (
    output rx_data, rx_done, tx_busy, tx_done,
    input  tx_din, tx_start, empty, full,
    input  count, overflow
  );

  modport slave (
    input  rx_data, rx_done, tx_busy, tx_done,
    output tx_din, tx_start, empty, full,
    output count, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Byte FIFO: register array, wrap pointers, occupancy count.
// A write while full is only accepted alongside a pop.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_data_i,
  input  logic        rd_en_i,
  output logic [7:0]  rd_data_o,
  output logic [AW:0] count_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          wr_ok;
  logic          rd_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign wr_ok     = wr_en_i & (~full_o | rd_en_i);
  assign rd_ok     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = count_q;

  // Occupancy next state: simultaneous push/pop cancels out
  always_comb begin
    count_d = count_q;
    if (wr_ok & ~rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok & ~wr_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers and count; power-of-two depth makes wrap implicit
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is left uninitialised; pointers define validity
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// Echo buffer: queues received bytes, replays them to tx.
// One byte in flight; rx_done level is edge-detected.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input logic              clk,
  input logic              rst,
  uart_echo_fifo_if.slave  bus
);

  rd_state_e   state_q;
  logic        rx_q;
  logic        ovf_q;
  logic [7:0]  tx_din_q;
  logic        tx_start_q;
  logic        we;
  logic        pop;
  logic [7:0]  rd_data;
  logic [AW:0] count;
  logic        empty;
  logic        full;

  assign we  = bus.rx_done & ~rx_q;
  assign pop = (state_q == IDLE) & ~empty & ~bus.tx_busy;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (we),
    .wr_data_i (bus.rx_data),
    .rd_en_i   (pop),
    .rd_data_o (rd_data),
    .count_o   (count),
    .empty_o   (empty),
    .full_o    (full)
  );

  // Previous rx_done level for rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) rx_q <= 1'b0;
    else     rx_q <= bus.rx_done;
  end

  // Sticky drop flag: write into a full FIFO with no pop
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (we & full & ~pop) begin
      ovf_q <= 1'b1;
    end
  end

  // Read FSM: pop, pulse tx_start once, wait for tx_done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_din_q   <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_start_q <= 1'b0;
          if (pop) begin
            tx_din_q   <= rd_data;
            tx_start_q <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          tx_start_q <= 1'b0;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          tx_start_q <= 1'b0;
          if (bus.tx_done) state_q <= IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_din   = tx_din_q;
  assign bus.tx_start = tx_start_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: queue-level reference model,
// directed scenarios and randomized traffic.
module tb_uart_echo_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_echo_fifo_if #(.AW(AW)) bus ();

  uart_echo_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue, the byte in flight, sticky drop flag
  logic [7:0] mq[$];
  int         since_pop = -1;
  logic       m_ovf     = 1'b0;
  logic [7:0] m_din     = 8'h00;
  logic       rx_prev   = 1'b0;
  bit         m_valid   = 1'b0;

  initial begin
    logic we;
    logic popped;
    logic was_full;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        since_pop = -1;
        m_ovf     = 1'b0;
        m_din     = 8'h00;
        rx_prev   = 1'b0;
        m_valid   = 1'b1;
      end else begin
        we       = bus.rx_done && !rx_prev;
        rx_prev  = bus.rx_done;
        was_full = (mq.size() == DEPTH);
        popped   = 1'b0;
        if (since_pop == 0) begin
          since_pop = 1;
        end else if (since_pop > 0) begin
          if (bus.tx_done) since_pop = -1;
        end else if (mq.size() > 0 && !bus.tx_busy) begin
          m_din     = mq.pop_front();
          since_pop = 0;
          popped    = 1'b1;
        end
        if (we) begin
          if (!was_full || popped) mq.push_back(bus.rx_data);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_vec();
    logic [3:0] c;
    c = 4'(mq.size());
    return {16'h0, c, mq.size() == 0, mq.size() == DEPTH,
            m_ovf, since_pop == 0, m_din};
  endfunction

  function automatic logic [31:0] act_vec();
    return {16'h0, bus.count, bus.empty, bus.full,
            bus.overflow, bus.tx_start, bus.tx_din};
  endfunction

  // Every cycle after the first reset edge, outputs must match the model
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) chk("model", act_vec(), exp_vec());
    end
  end

  // Record every byte handed to the transmitter
  logic [7:0] sent[$];
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_start) sent.push_back(bus.tx_din);
    end
  end

  // Transmitter stand-in: tx_done a set delay after each tx_start
  int resp_dly  = 3;
  bit resp_on   = 1'b1;
  bit rand_dly  = 1'b0;
  int noise_pct = 0;

  initial begin
    int cnt;
    cnt = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
      if (!resp_on) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.tx_done = 1'b1;
      end else if (bus.tx_start) begin
        cnt = rand_dly ? int'($urandom_range(1, 8)) : resp_dly;
      end
      if (cnt == 0 && !bus.tx_done &&
          $urandom_range(99) < noise_pct)
        bus.tx_done = 1'b1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    sent.delete();
  endtask

  task automatic chk_seq(input string name, input bq_t e);
    chk({name, "_len"}, sent.size(), e.size());
    for (int i = 0; i < e.size() && i < sent.size(); i++)
      chk(name, sent[i], e[i]);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_count"}, bus.count, 0);
    chk({name, "_empty"}, bus.empty, 1);
    chk({name, "_full"}, bus.full, 0);
    chk({name, "_ovf"}, bus.overflow, 0);
    chk({name, "_start"}, bus.tx_start, 0);
    chk({name, "_din"}, bus.tx_din, 8'h00);
  endtask

  initial begin
    bq_t e;
    int  hold;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_busy = 1'b0;

    do_reset();
    chk_reset_vals("rst");

    // Single byte: start two cycles after the rx_done pulse
    bus.rx_data = 8'h31;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    chk("single_cnt1", bus.count, 1);
    chk("single_nostart", bus.tx_start, 0);
    step();
    chk("single_start", bus.tx_start, 1);
    chk("single_din", bus.tx_din, 8'h31);
    chk("single_cnt0", bus.count, 0);
    step();
    chk("single_onecyc", bus.tx_start, 0);
    step(10);
    e = {8'h31};
    chk_seq("single_seq", e);

    // Level rx_done held five cycles: one write only
    do_reset();
    bus.tx_busy = 1'b1;
    bus.rx_data = 8'hA5;
    bus.rx_done = 1'b1;
    step(5);
    bus.rx_done = 1'b0;
    step();
    chk("level_cnt", bus.count, 1);
    bus.tx_busy = 1'b0;
    step(20);
    e = {8'hA5};
    chk_seq("level_seq", e);

    // Order and pointer wrap, slow transmitter
    do_reset();
    resp_dly = 50;
    for (int i = 0; i < 12; i++) begin
      bus.rx_data = 8'(i);
      bus.rx_done = 1'b1;
      step();
      bus.rx_done = 1'b0;
      step(19);
    end
    step(700);
    e = {};
    for (int i = 0; i < 12; i++) e.push_back(8'(i));
    chk_seq("wrap_seq", e);
    chk("wrap_ovf", bus.overflow, 0);
    chk("wrap_cnt", bus.count, 0);
    resp_dly = 3;

    // Full plus simultaneous pop and write
    do_reset();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    chk("simul_full", bus.full, 1);
    bus.tx_busy = 1'b0;
    bus.rx_data = 8'h77;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    chk("simul_cnt", bus.count, 8);
    chk("simul_ovf", bus.overflow, 0);
    step(100);
    e = {};
    for (int i = 0; i < 8; i++) e.push_back(8'h20 + 8'(i));
    e.push_back(8'h77);
    chk_seq("simul_seq", e);
    chk("simul_ovf_end", bus.overflow, 0);

    // Overflow: ninth byte dropped, flag sticky
    do_reset();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    chk("ovf_full", bus.full, 1);
    chk("ovf_cnt8", bus.count, 8);
    chk("ovf_pre", bus.overflow, 0);
    send(8'h18);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_cnt", bus.count, 8);
    bus.tx_busy = 1'b0;
    step(80);
    e = {};
    for (int i = 0; i < 8; i++) e.push_back(8'h10 + 8'(i));
    chk_seq("ovf_seq", e);
    chk("ovf_sticky", bus.overflow, 1);

    // Reset in WAIT_DONE with three bytes queued
    do_reset();
    resp_on = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i));
    step(2);
    chk("mid_cnt", bus.count, 3);
    chk("mid_inflight", sent.size(), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("mid_rst");
    sent.delete();
    noise_pct = 30;
    step(30);
    noise_pct = 0;
    chk("mid_quiet", sent.size(), 0);
    resp_on = 1'b1;
    send(8'h55);
    step(4);
    e = {8'h55};
    chk_seq("mid_new", e);

    // Randomized traffic with busy, spurious tx_done and resets
    do_reset();
    rand_dly  = 1'b1;
    noise_pct = 3;
    hold      = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = 1'b0;
      if (hold > 0) begin
        hold--;
        if (hold == 0) bus.rx_done = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        bus.rx_data = 8'($urandom);
        bus.rx_done = 1'b1;
        hold = int'($urandom_range(1, 3));
      end
      bus.tx_busy = ($urandom_range(9) < 2);
      if ($urandom_range(999) == 0) rst = 1'b1;
      step();
    end
    rst         = 1'b0;
    bus.rx_done = 1'b0;
    bus.tx_busy = 1'b0;
    noise_pct   = 0;
    rand_dly    = 1'b0;
    step(150);
    chk("rand_drained", bus.count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
